adder64_reg: RTL and testbench
==============================

// Module: adder64_reg
// PURPOSE
//  - Registered two's-complement adder: sum = a + b + cin, with carry-out and signed overflow.
//  - Default use is the program counter's next-sequential-address path (instruction_address + 4, cin=0).
//  - Also serves as a general datapath adder.
//  - Internally a carry-lookahead adder built from 4-bit CLA groups with rippled group carries.
//  - Result is captured in an output register.
// PARAMETERS
//  - WIDTH  64  operand/result width; must be a multiple of 4, minimum 4.
// PORTS
//  - clk        input   1      rising-edge clock
//  - rst_n      input   1      asynchronous, active-low reset
//  - in_valid   input   1      operands on a/b/cin are valid this cycle
//  - a          input   WIDTH  operand A, unsigned or two's complement
//  - b          input   WIDTH  operand B
//  - cin        input   1      carry-in
//  - sum        output  WIDTH  registered (a+b+cin) mod 2^WIDTH
//  - cout       output  1      registered carry out of bit WIDTH-1
//  - overflow   output  1      registered signed overflow
//  - out_valid  output  1      sum/cout/overflow hold a result captured from an in_valid cycle
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: on rst_n=0, immediately and independent of clk, sum=0, cout=0, overflow=0, out_valid=0.
//    These values hold while rst_n=0.
//    The first capture happens on the first rising clk edge after rst_n deasserts.
//  - Latency: exactly 1 cycle; throughput 1 result per cycle, no stall or backpressure.
//  - Capture rule, each rising clk edge with rst_n=1:
//    - in_valid=1: sum/cout/overflow <= result of the current a/b/cin; out_valid <= 1.
//    - in_valid=0: sum/cout/overflow hold their previous values; out_valid <= 0.
//  - Arithmetic: full WIDTH+1-bit result {cout,sum} = a + b + cin.
//    Wrap-around is modulo 2^WIDTH, with no saturation.
//  - overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), taken from the unregistered result before capture.
//  - CLA group (4 bits):
//    - p_i = a_i^b_i; g_i = a_i&b_i.
//    - c_{i+1} = g_i | p_i&c_i, expanded as lookahead within the group.
//    - Group outputs: s_i = p_i ^ c_i, plus group P and G.
//    - Group carry-in for group k = carry-out of group k-1; group 0 uses cin.
//  - No X-propagation tolerance is required.
//    The output register must not capture while rst_n=0, even when in_valid=1.
//  - Reset asserted mid-stream discards any result in flight; out_valid drops asynchronously.
// STRUCTURE
//  - Shared package: WIDTH default constant (64), constant CLA_GROUP=4.
//  - One sub-module: cla4 (inputs a[3:0], b[3:0], ci; outputs s[3:0], co, gp, gg).
//    Instantiated WIDTH/4 times via generate.
//  - Top holds the generate chain, the overflow logic and the output register.
// TESTING
//  - T1 PC increment: a=0, b=4, cin=0, in_valid=1 -> next cycle sum=4, cout=0, overflow=0, out_valid=1.
//  - T2 wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, overflow=0.
//  - T3 signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000, cout=0, overflow=1.
//    Also a=b=64'h8000_0000_0000_0000 -> sum=0, cout=1, overflow=1.
//  - T4 carry-in and cross-group carry:
//    - a=0, b=0, cin=1 -> sum=1.
//    - a=64'h0000_0000_0000_000F, b=1 -> sum=64'h10; exercises the group boundary.
//  - T5 stream/hold: back-to-back 0+4, 4+4, 8+4 -> sums 4, 8, 12 on consecutive cycles.
//    Then in_valid=0 -> sum holds 12, out_valid=0.
//  - T6 async reset: assert rst_n=0 between clock edges while sum=12 -> outputs 0 before the next edge.
//    Deassert, then a=5, b=7 -> sum=12 one cycle later.
//  - Also: 10k random vectors against a behavioural a+b+cin model.

Source files
------------

// File: rtl/adder64_reg_pkg.sv
// Shared constants for the registered CLA adder.
package adder64_reg_pkg;
  localparam int unsigned WIDTH_DEFAULT = 64;
  localparam int unsigned CLA_GROUP     = 4;
endpackage

// File: rtl/adder64_reg_cla4.sv
// 4-bit carry-lookahead group: sum bits, carry out, and group propagate/generate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       gp,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Carries fully expanded so no bit waits on its neighbour inside the group.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign co = gg | (gp & ci);

  assign s = p ^ c;
endmodule

// File: rtl/adder64_reg.sv
// Registered two's-complement adder (sum, carry-out, signed overflow) built from
// a ripple chain of 4-bit CLA groups; default use is the PC+4 path.
module adder64_reg
  import adder64_reg_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);
  localparam int unsigned NGROUPS = WIDTH / CLA_GROUP;

  logic [NGROUPS:0]   carry;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS-1:0] grp_g;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_d;
  logic               ovf_d;

  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               valid_q;

  assign carry[0] = cin;

  genvar k;
  generate
    for (k = 0; k < NGROUPS; k++) begin : g_cla
      cla4 u_cla4 (
        .a  (a[k*CLA_GROUP +: CLA_GROUP]),
        .b  (b[k*CLA_GROUP +: CLA_GROUP]),
        .ci (carry[k]),
        .s  (sum_d[k*CLA_GROUP +: CLA_GROUP]),
        .co (carry[k+1]),
        .gp (grp_p[k]),
        .gg (grp_g[k])
      );
    end
  endgenerate

  // Group P/G are kept for a future second lookahead level; the chain ripples today.
  logic unused_group_pg;
  assign unused_group_pg = ^{grp_p, grp_g};

  assign cout_d = carry[NGROUPS];
  assign ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_adder64_reg.sv
// Self-checking bench for adder64_reg: directed corner cases plus random vectors
// against a plain-arithmetic model of the registered adder.
module tb_adder64_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  adder64_reg #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Model: full-precision unsigned and signed sums, captured like a register.
  logic [63:0] m_sum   = '0;
  logic        m_cout  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic        m_valid = 1'b0;
  logic [64:0] m_full;
  logic [64:0] m_signed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b0;
    end else if (in_valid) begin
      m_full   = {1'b0, a} + {1'b0, b} + {64'b0, cin};
      m_signed = $signed({a[63], a}) + $signed({b[63], b}) + $signed({64'b0, cin});
      m_sum   <= m_full[63:0];
      m_cout  <= m_full[64];
      m_ovf   <= (m_signed[64] != m_signed[63]);
      m_valid <= 1'b1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model.sum",       sum,             m_sum);
      check("model.cout",      {63'b0, cout},      {63'b0, m_cout});
      check("model.overflow",  {63'b0, overflow},  {63'b0, m_ovf});
      check("model.out_valid", {63'b0, out_valid}, {63'b0, m_valid});
    end
  end

  task automatic apply(input logic [63:0] ta, input logic [63:0] tb, input logic tc, input logic tv);
    a = ta; b = tb; cin = tc; in_valid = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [63:0] es, input logic ec,
                            input logic eo, input logic ev);
    check({name, ".sum"},       sum,              es);
    check({name, ".cout"},      {63'b0, cout},      {63'b0, ec});
    check({name, ".overflow"},  {63'b0, overflow},  {63'b0, eo});
    check({name, ".out_valid"}, {63'b0, out_valid}, {63'b0, ev});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 64'd1; b = 64'd1; cin = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 expect_out("reset_hold", 64'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    apply(64'd0, 64'd4, 1'b0, 1'b1);
    expect_out("T1_pc4", 64'd4, 1'b0, 1'b0, 1'b1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    expect_out("T2_wrap", 64'd0, 1'b1, 1'b0, 1'b1);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    expect_out("T3_posovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    expect_out("T3_negovf", 64'd0, 1'b1, 1'b1, 1'b1);
    apply(64'd0, 64'd0, 1'b1, 1'b1);
    expect_out("T4_cin", 64'd1, 1'b0, 1'b0, 1'b1);
    apply(64'h0000_0000_0000_000F, 64'd1, 1'b0, 1'b1);
    expect_out("T4_group", 64'h10, 1'b0, 1'b0, 1'b1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    expect_out("T4_fullchain", 64'd0, 1'b1, 1'b0, 1'b1);

    apply(64'd0, 64'd4, 1'b0, 1'b1);
    expect_out("T5_s0", 64'd4, 1'b0, 1'b0, 1'b1);
    apply(64'd4, 64'd4, 1'b0, 1'b1);
    expect_out("T5_s1", 64'd8, 1'b0, 1'b0, 1'b1);
    apply(64'd8, 64'd4, 1'b0, 1'b1);
    expect_out("T5_s2", 64'd12, 1'b0, 1'b0, 1'b1);
    apply(64'd100, 64'd100, 1'b1, 1'b0);
    expect_out("T5_hold", 64'd12, 1'b0, 1'b0, 1'b0);

    // Async reset between edges, with in_valid held high to prove no capture.
    a = 64'd3; b = 64'd3; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 expect_out("T6_async", 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 expect_out("T6_noload", 64'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    apply(64'd5, 64'd7, 1'b0, 1'b1);
    expect_out("T6_after", 64'd12, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = {ra[63], {63{~ra[63]}}};
        1: rb = ~ra;
        2: rb = 64'd4;
        default: ;
      endcase
      apply(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
    end

    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
